// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types and helpers for the memory arbiter slice.
//   - ADDR_W_DEF / DATA_W_DEF : default bus widths
//   - MAX_ID_W                : storage width of a requester id inside a tag
//                               (covers up to 256 requesters)
//   - port_id_w()             : bits needed to name one of n ports (min 1)
//   - tag_t                   : one tag-pipeline entry {valid, id, is_write}
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int MAX_ID_W   = 8;

    function automatic int port_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The id field is sized for the largest supported arbiter so the tag
    // type can live in the package. The top only compares it against
    // zero-extended port numbers.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
        logic                is_write;
    } tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Requester-side bus of the memory arbiter.
//   - req_valid/req_write/req_addr/req_wdata : per-port request, held until ready
//   - req_ready                               : per-port grant (one-hot or zero)
//   - rsp_valid                               : per-port one-cycle response pulse
//   - rsp_rdata                               : shared load data, valid with rsp_valid
//   modport slave  : arbiter side
//   modport master : requester side
interface mem_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) ();

    logic [NUM_PORTS-1:0]             req_valid;
    logic [NUM_PORTS-1:0]             req_write;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_PORTS-1:0]             req_ready;
    logic [NUM_PORTS-1:0]             rsp_valid;
    logic [DATA_W-1:0]                rsp_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter: combinational grant of the first valid port found
//   scanning rr_ptr, rr_ptr+1, ... (mod NUM_PORTS), plus the registered
//   pointer update (rr_ptr <= granted+1, unchanged when nothing is granted).
//   Ports:
//   - clk, reset  : clock, synchronous active-low reset
//   - req_valid   : per-port request
//   - grant       : one-hot grant or zero
//   - grant_id    : index of the granted port (0 when no grant)
//   - grant_any   : any port granted this cycle
module rr_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int PTR_W     = port_id_w(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req_valid,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PTR_W-1:0]     grant_id,
    output logic                 grant_any
);

    logic [PTR_W-1:0] rr_ptr;

    // Scan from the farthest candidate back toward rr_ptr so the last hit
    // (the one nearest rr_ptr in round-robin order) wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            int p;
            p = int'(rr_ptr) + k;
            if (p >= NUM_PORTS) p = p - NUM_PORTS;
            if (req_valid[p]) begin
                grant     = '0;
                grant[p]  = 1'b1;
                grant_id  = PTR_W'(p);
                grant_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (int'(grant_id) == NUM_PORTS - 1) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Merges NUM_PORTS single-lane request streams onto one memory port.
//   Round-robin grant, one access issued per cycle, and a fixed-latency tag
//   pipeline that routes each response back to its requester.
//   Ports:
//   - clk, reset : clock, synchronous active-low reset
//   - bus        : requester bus (slave side): requests in, ready/responses out
//   - mem_addr   : registered memory address (0 when idle)
//   - mem_wdata  : registered store data (0 when idle)
//   - mem_write  : registered write strobe
//   - mem_rdata  : memory read data, RD_LATENCY cycles after mem_addr
//   Grant at edge T -> mem_* in cycle T+1 -> rsp in cycle T+2+RD_LATENCY.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int ID_W = port_id_w(NUM_PORTS);

    logic [NUM_PORTS-1:0] grant;
    logic [ID_W-1:0]      grant_id;
    logic                 grant_any;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req_valid (bus.req_valid),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    // Grant only ever selects a valid port, so ready itself marks the transfer.
    assign bus.req_ready = grant;

    // Issue stage: idle cycles drive an all-zero access.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
        end else if (grant_any) begin
            mem_addr  <= bus.req_addr[grant_id];
            mem_wdata <= bus.req_wdata[grant_id];
            mem_write <= bus.req_write[grant_id];
        end else begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_write <= 1'b0;
        end
    end

    // Tag pipeline: stage 0 lines up with mem_* and the last stage lines up
    // with mem_rdata, so the exiting tag and its load data share a cycle.
    tag_t tag_pipe [RD_LATENCY:0];
    tag_t tag_exit;

    assign tag_exit = tag_pipe[RD_LATENCY];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i <= RD_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0].valid    <= grant_any;
            tag_pipe[0].id       <= MAX_ID_W'(grant_id);
            tag_pipe[0].is_write <= grant_any & bus.req_write[grant_id];
            for (int i = 1; i <= RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Response stage: route the exiting tag back to its requester. Stores
    // get a zero-data ack.
    logic [NUM_PORTS-1:0] rsp_valid_q;
    logic [DATA_W-1:0]    rsp_rdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++)
                rsp_valid_q[p] <= tag_exit.valid && (tag_exit.id == MAX_ID_W'(p));
            rsp_rdata_q <= (tag_exit.valid && !tag_exit.is_write) ? mem_rdata : '0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NP = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RL = 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_write;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RL)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: word i preloads A000+i, 0x40 holds BEEF. Read data registered
    // one cycle after the address; a store lands at the end of its cycle.
    logic [DW-1:0] mem [0:255];
    logic          mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
            mem[8'h40] <= 16'hBEEF;
            mem_rdata  <= '0;
            mem_init   <= 1'b1;
        end else begin
            if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic chk_rsp(input string tag, input logic [3:0] v, input logic [15:0] d);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(v));
        chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'(d));
    endtask

    int g4 [5] = '{0, 1, 2, 3, 0};
    int gf [3] = '{1, 3, 1};

    initial begin
        idle_in();
        reset = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk_rsp("rst", 4'h0, 16'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        chk("rst_rr_ptr", 32'(u_dut.u_rr.rr_ptr), 32'h0);
        reset = 1'b1;
        tick();

        // Single load: port 2, addr 0x0040
        bus.req_valid   = 4'b0100;
        bus.req_addr[2] = 16'h0040;
        #1;
        chk("t1_ready", 32'(bus.req_ready), 32'h4);
        tick();
        idle_in();
        chk("t1_mem_addr", 32'(mem_addr), 32'h0040);
        chk("t1_mem_write", 32'(mem_write), 32'h0);
        chk_rsp("t1_c1", 4'h0, 16'h0);
        chk("t1_rr_ptr", 32'(u_dut.u_rr.rr_ptr), 32'h3);
        tick();
        chk("t1_mem_addr_idle", 32'(mem_addr), 32'h0);
        chk_rsp("t1_c2", 4'h0, 16'h0);
        tick();
        chk_rsp("t1_c3", 4'b0100, 16'hBEEF);
        tick();
        chk_rsp("t1_c4", 4'h0, 16'h0);

        // Back-to-back port 3, addresses 0x20..0x24
        for (int t = 0; t < 8; t++) begin
            if (t < 5) begin
                bus.req_valid   = 4'b1000;
                bus.req_addr[3] = 16'h0020 + 16'(t);
                #1;
                chk("b2b_ready", 32'(bus.req_ready), 32'h8);
            end else begin
                idle_in();
            end
            tick();
            chk("b2b_mem_addr", 32'(mem_addr), (t < 5) ? 32'h20 + 32'(t) : 32'h0);
            if (t >= 2 && t < 7) chk_rsp("b2b", 4'b1000, 16'hA020 + 16'(t - 2));
            else                 chk_rsp("b2b_idle", 4'h0, 16'h0);
        end
        chk("b2b_rr_ptr", 32'(u_dut.u_rr.rr_ptr), 32'h0);

        // All four valid from rr_ptr=0: grants 0,1,2,3,0
        for (int t = 0; t < 8; t++) begin
            if (t < 5) begin
                bus.req_valid = 4'b1111;
                for (int p = 0; p < NP; p++) bus.req_addr[p] = 16'h0030 + 16'(p);
                #1;
                chk("rr4_ready", 32'(bus.req_ready), 32'(1) << g4[t]);
            end else begin
                idle_in();
            end
            tick();
            chk("rr4_mem_addr", 32'(mem_addr), (t < 5) ? 32'h30 + 32'(g4[t]) : 32'h0);
            if (t >= 2 && t < 7)
                chk_rsp("rr4", 4'(1 << g4[t-2]), 16'hA030 + 16'(g4[t-2]));
            else
                chk_rsp("rr4_idle", 4'h0, 16'h0);
        end
        chk("rr4_rr_ptr", 32'(u_dut.u_rr.rr_ptr), 32'h1);

        // Store 0x1234 @0x10 from port 0, then load 0x10 from port 1
        bus.req_valid    = 4'b0001;
        bus.req_write[0] = 1'b1;
        bus.req_addr[0]  = 16'h0010;
        bus.req_wdata[0] = 16'h1234;
        #1;
        chk("st_ready", 32'(bus.req_ready), 32'h1);
        tick();
        idle_in();
        bus.req_valid   = 4'b0010;
        bus.req_addr[1] = 16'h0010;
        chk("st_mem_write", 32'(mem_write), 32'h1);
        chk("st_mem_addr", 32'(mem_addr), 32'h0010);
        chk("st_mem_wdata", 32'(mem_wdata), 32'h1234);
        #1;
        chk("ld_ready", 32'(bus.req_ready), 32'h2);
        tick();
        idle_in();
        chk("ld_mem_write", 32'(mem_write), 32'h0);
        chk("ld_mem_addr", 32'(mem_addr), 32'h0010);
        chk("ld_mem_wdata", 32'(mem_wdata), 32'h0);
        tick();
        chk_rsp("st_ack", 4'b0001, 16'h0);
        chk("st_mem_write_done", 32'(mem_write), 32'h0);
        tick();
        chk_rsp("ld_rsp", 4'b0010, 16'h1234);
        tick();
        chk_rsp("stld_idle", 4'h0, 16'h0);
        chk("stld_rr_ptr", 32'(u_dut.u_rr.rr_ptr), 32'h2);

        // Reset mid-flight: grants 2,0,1 then reset low for one cycle
        bus.req_valid = 4'b0111;
        for (int p = 0; p < NP; p++) bus.req_addr[p] = 16'h0060 + 16'(p);
        #1;
        chk("mf_ready0", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'b0011;
        #1;
        chk("mf_ready1", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b0010;
        #1;
        chk("mf_ready2", 32'(bus.req_ready), 32'h2);
        tick();
        chk_rsp("mf_first", 4'b0100, 16'hA062);
        chk("mf_mem_addr", 32'(mem_addr), 32'h0061);
        idle_in();
        reset = 1'b0;
        tick();
        chk_rsp("mf_rst", 4'h0, 16'h0);
        chk("mf_rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("mf_rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("mf_rst_mem_write", 32'(mem_write), 32'h0);
        chk("mf_rst_rr_ptr", 32'(u_dut.u_rr.rr_ptr), 32'h0);
        chk("mf_rst_ready", 32'(bus.req_ready), 32'h0);
        reset = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk_rsp("mf_after", 4'h0, 16'h0);
        end

        // Fairness from rr_ptr=0 with ports 1 and 3 valid: grants 1,3,1
        bus.req_addr[1] = 16'h0051;
        bus.req_addr[3] = 16'h0053;
        for (int t = 0; t < 6; t++) begin
            if (t < 3) begin
                bus.req_valid = 4'b1010;
                #1;
                chk("fair_ready", 32'(bus.req_ready), 32'(1) << gf[t]);
            end else begin
                idle_in();
            end
            tick();
            chk("fair_mem_addr", 32'(mem_addr), (t < 3) ? 32'h50 + 32'(gf[t]) : 32'h0);
            if (t >= 2 && t < 5)
                chk_rsp("fair", 4'(1 << gf[t-2]), 16'hA050 + 16'(gf[t-2]));
            else
                chk_rsp("fair_idle", 4'h0, 16'h0);
        end
        chk("fair_rr_ptr", 32'(u_dut.u_rr.rr_ptr), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Multi-requester memory arbiter sitting directly downstream of the per-core memory schedulers. It merges NUM_PORTS serialized single-lane request streams onto the one shared data-memory port. It grants round-robin, issues at most one access per cycle, and tracks requester IDs through a fixed-latency tag pipeline so each read/write response returns to its originator. It is fully pipelined: one grant per cycle, with no memory-side backpressure.

## Interface
Parameters:
- NUM_PORTS, 4, number of requesters (≥1)
- ADDR_W, 16, address width
- DATA_W, 16, data width
- RD_LATENCY, 1, cycles from mem_addr registered to mem_rdata valid (≥1)

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-low; reset==0 at posedge clears state
- req_valid  in  NUM_PORTS  per-port request valid
- req_write  in  NUM_PORTS  1=store, 0=load
- req_addr  in  [NUM_PORTS] x ADDR_W  per-port address
- req_wdata  in  [NUM_PORTS] x DATA_W  per-port store data
- req_ready  out  NUM_PORTS  combinational grant; one-hot or zero
- rsp_valid  out  NUM_PORTS  one-cycle response pulse, one-hot or zero
- rsp_rdata  out  DATA_W  load data, shared; valid with rsp_valid
- mem_addr  out  ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered memory store data
- mem_write  out  1  registered write strobe
- mem_rdata  in  DATA_W  memory read data, RD_LATENCY after mem_addr

## Operation
- Handshake: transfer on req_valid[i] & req_ready[i]. The requester holds valid/write/addr/wdata stable until ready. ready never depends on any other port's ready.
- Arbitration: rr_ptr (clog2(NUM_PORTS) bits). Grant the first valid port scanning rr_ptr, rr_ptr+1, … modulo NUM_PORTS. On grant to port g, rr_ptr <= (g+1) mod NUM_PORTS. No grant leaves rr_ptr unchanged.
- Issue stage: the granted request is registered onto mem_addr/mem_wdata/mem_write.
  - With no grant: mem_write=0, mem_addr=0, mem_wdata=0.
- Tag pipeline: depth RD_LATENCY+1. Entry = {valid, port_id, is_write}. Pushed on each grant; shifts every cycle.
- Response stage (registered): when the tag exits, rsp_valid[port_id]=1 for one cycle.
  - Loads: rsp_rdata=mem_rdata.
  - Stores: rsp_rdata=0; the pulse is the store ack.
  - No tag exiting: rsp_valid=0, rsp_rdata=0.
- Ordering: responses return in grant order. Per-port order is preserved.
- NUM_PORTS=1: req_ready=req_valid. rr_ptr is constant 0.
- Reset values: req_ready follows arbitration (0 while reset is held low); rsp_valid=0, rsp_rdata=0, mem_addr=0, mem_wdata=0, mem_write=0, rr_ptr=0, all tags invalid.
- Reset mid-operation: in-flight accesses are dropped. No response is emitted for them. A store already registered on mem_write is not cancelled.

## Timing
- Grant at edge T (valid&ready sampled) → mem_* driven during cycle T+1.
- mem_rdata is valid during cycle T+1+RD_LATENCY and is registered at the end of that cycle.
- rsp_valid is visible during cycle T+2+RD_LATENCY. With default RD_LATENCY=1, response arrives 3 cycles after grant.
- Throughput: 1 grant/cycle. Maximum in-flight is RD_LATENCY+2.
- Store reaches memory in cycle T+1. A load granted at T+1 or later sees the new data, since memory is write-before-read on the same address across cycles.
- Simultaneous grant and response: independent. The tag push and the exit happen in the same cycle without conflict.

## Structure
- mem_pkg: ADDR_W/DATA_W defaults, PORT_ID_W function (clog2), tag struct typedef {logic valid; logic [PORT_ID_W-1:0] id; logic is_write}.
- Sub-module rr_arbiter: combinational grant from req_valid and rr_ptr, plus the registered rr_ptr update. Parameterized by NUM_PORTS; reused by future arbiters.
- Top: issue registers, tag shift register, response register.

## Test plan
- Single load: port 2 reads addr 0x0040 (mem holds 0xBEEF); grant at T → mem_addr=0x0040 at T+1, rsp_valid=4'b0100 with rsp_rdata=0xBEEF at T+3.
- All four valid continuously from rr_ptr=0 → grants 0,1,2,3,0 in consecutive cycles; responses in the same order, one per cycle.
- Fairness: rr_ptr=0, ports 1 and 3 valid → grant 1; next cycle port 1 still valid and port 3 valid → grant 3, then 1.
- Store then load: port 0 stores 0x1234 to 0x0010, port 1 loads 0x0010 the next cycle → mem_write=1 for exactly one cycle, port 0 ack rsp_rdata=0, port 1 rsp_rdata=0x1234.
- Reset mid-flight: three loads granted, reset low one cycle after the last grant → no rsp_valid at any time after reset; all outputs 0; rr_ptr=0.
- Back-to-back single port: port 3 valid for 5 cycles with incrementing addresses → 5 grants, 5 in-order responses, no idle bubble.
